hazard_unit: RTL
================

# hazard_unit

Pipeline interlock controller for the 5-stage MIPS core. It sits beside the decode stage, directly upstream of the operand-forwarding muxes. It resolves the hazards that forwarding cannot cover:
- load-use dependencies;
- accesses to the multi-cycle multiply/divide unit and HI/LO;
- taken-branch redirection.

It owns the mul/div busy counter and drives the stall/flush controls of the IF/ID and ID/EX pipeline registers.

## Interface
Parameters:
- MULT_LAT, 4: cycles from mult/multu issue until HI/LO is valid.
- DIV_LAT, 32: cycles from div/divu issue until HI/LO is valid.
- CNT_W, 6: counter width; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  core clock. Single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ra_rs_id  in  5  rs register address of the instruction in ID.
- ra_rt_id  in  5  rt register address of the instruction in ID.
- use_rs_id  in  1  the ID instruction reads rs.
- use_rt_id  in  1  the ID instruction reads rt.
- ra_ex  in  5  destination register of the instruction in EX.
- memread_ex  in  1  the instruction in EX is a load.
- md_start_ex  in  1  a valid mult/multu/div/divu is in EX this cycle.
- md_div_ex  in  1  the md_start_ex op is a divide.
- md_op_id  in  1  the ID instruction is mult/multu/div/divu.
- hilo_rd_id  in  1  the ID instruction is mfhi/mflo.
- hilo_wr_id  in  1  the ID instruction is mthi/mtlo.
- br_taken_ex  in  1  branch/jump in EX resolved taken.
- stall_if  out  1  hold PC and the IF/ID register.
- stall_id  out  1  hold the ID instruction.
- flush_if  out  1  load a bubble into IF/ID.
- flush_ex  out  1  load a bubble into ID/EX.
- md_busy  out  1  mul/div unit is computing.
- md_done  out  1  single-cycle pulse: HI/LO is written this cycle.

## Operation
- Load-use hazard, defined as `lu`:
  - Condition: memread_ex && ra_ex != 0 && ((use_rs_id && ra_rs_id == ra_ex) || (use_rt_id && ra_rt_id == ra_ex)).
  - Response: stall_if = stall_id = flush_ex = 1 for exactly one cycle. Next cycle the load is in MEM and forwarding covers the dependency.
- HI/LO hazard, defined as `md`:
  - Condition: (md_op_id || hilo_rd_id || hilo_wr_id) && (md_busy || md_start_ex).
  - Response: stall_if = stall_id = flush_ex = 1 while the condition holds.
- Branch:
  - br_taken_ex has the highest priority. The delay-slot instruction (in ID) proceeds normally.
  - Response: flush_if = 1, stall_if = stall_id = 0, flush_ex = 0. This holds even if `lu` or `md` is true that cycle.
  - A stall caused by the delay slot is re-evaluated the following cycle.
- Mul/div counter `cnt` (CNT_W bits):
  - On rst: cnt <= 0.
  - Else if md_start_ex && cnt == 0: cnt <= md_div_ex ? DIV_LAT : MULT_LAT.
  - Else if cnt != 0: cnt <= cnt - 1.
  - md_start_ex while cnt != 0 cannot occur, because the `md` stall blocks it. If it does occur, it is ignored, with no reload.
- md_busy = (cnt != 0).
- md_done = (cnt == 1). HI/LO is written on that edge. The cycle after md_done, a waiting mfhi/mflo is released.
- While rst = 1, all stall and flush outputs are forced to 0 and md_busy = md_done = 0.

## Timing
- `lu`, `md` and branch decoding are purely combinational from inputs and `cnt`, with no register on the stall outputs.
- Reset values: cnt = 0, md_busy = 0, md_done = 0, stall_if = stall_id = flush_if = flush_ex = 0.
- Mul/div latency:
  - mult issued in EX at cycle T: md_busy high for cycles T+1 .. T+MULT_LAT; md_done at T+MULT_LAT.
  - An mflo stalled in ID leaves ID at cycle T+MULT_LAT+1.
- Back-to-back md ops: the second op stalls in ID during T (via md_start_ex) and throughout busy. It enters EX at T+LAT+1.
- Reset mid-operation: cnt clears on the next edge. The in-flight result is abandoned and md_done is not pulsed.
- Simultaneous `lu` and `md`: same outputs, one stall. No extra cycle beyond the longer condition.
- Register 0 never causes a load-use stall.

## Structure
- Shared package `mips_defs` holds:
  - the default MULT_LAT/DIV_LAT constants;
  - the register-address width (5);
  - the REG_ZERO constant.
- One natural sub-module, `md_counter`: the load/decrement counter, with md_busy and md_done outputs. All hazard decode stays in hazard_unit.

## Test plan
- Load-use on rs:
  - Stimulus: memread_ex=1, ra_ex=5; ID reads rs=5.
  - Required: one cycle of stall_if=stall_id=flush_ex=1.
  - Next cycle, with memread_ex=0: all outputs 0.
- Load to $0:
  - Stimulus: ra_ex=0, use_rs_id=1, ra_rs_id=0.
  - Required: no stall.
- mult then mflo:
  - Stimulus: md_start_ex at cycle 10, MULT_LAT=4; mflo in ID.
  - Required: stall cycles 10–14; md_done at cycle 14; stall released at cycle 15.
- div then div:
  - Stimulus: second div in ID while the first issues.
  - Required: stall for 33 cycles (issue cycle plus DIV_LAT busy cycles); cnt reloads to 32 only once the second div enters EX.
- Branch priority:
  - Stimulus: br_taken_ex=1 together with a load-use condition.
  - Required: flush_if=1, stall_if=stall_id=flush_ex=0.
- Reset mid-divide:
  - Stimulus: assert rst at cnt=20.
  - Required: next cycle cnt=0, md_busy=0, md_done never pulses, all stall/flush outputs 0.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS core constants: register address width, $zero and default mul/div latencies.
package mips_defs;
  localparam int REG_W        = 5;
  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 32;
  localparam int CNT_W_DEF    = 6;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/md_counter.sv
// Mul/div busy counter: loads the op latency on issue and counts down to the HI/LO write.
// Latency: busy from the cycle after issue; done pulses in the last busy cycle. No backpressure.
module md_counter #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // An issue while already counting is ignored; the decode stall keeps it from happening.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start && cnt == '0) begin
      cnt <= is_div ? DIV_CNT : MULT_CNT;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign busy = !rst && (cnt != '0);
  assign done = !rst && (cnt == ONE);
endmodule

// File: rtl/hazard_unit.sv
// Decode-stage interlock: load-use and HI/LO stalls, taken-branch IF flush; all outputs combinational.
// Branch redirect overrides any stall; the stalled ID instruction is re-evaluated the next cycle.
module hazard_unit
  import mips_defs::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ra_rs_id,
  input  logic [REG_W-1:0] ra_rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic [REG_W-1:0] ra_ex,
  input  logic             memread_ex,
  input  logic             md_start_ex,
  input  logic             md_div_ex,
  input  logic             md_op_id,
  input  logic             hilo_rd_id,
  input  logic             hilo_wr_id,
  input  logic             br_taken_ex,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_if,
  output logic             flush_ex,
  output logic             md_busy,
  output logic             md_done
);
  logic lu;
  logic md;

  md_counter #(
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md_counter (
    .clk   (clk),
    .rst   (rst),
    .start (md_start_ex),
    .is_div(md_div_ex),
    .busy  (md_busy),
    .done  (md_done)
  );

  assign lu = memread_ex && (ra_ex != REG_ZERO) &&
              ((use_rs_id && ra_rs_id == ra_ex) || (use_rt_id && ra_rt_id == ra_ex));

  // An op issuing in EX this cycle counts as busy so a following HI/LO access waits.
  assign md = (md_op_id || hilo_rd_id || hilo_wr_id) && (md_busy || md_start_ex);

  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_if = 1'b0;
    flush_ex = 1'b0;
    if (!rst) begin
      if (br_taken_ex) begin
        flush_if = 1'b1;
      end else if (lu || md) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end
endmodule
